// File: rtl/delay_timer_if.sv
// Handshake bundle between the 1101 detector/user side and delay_timer.
// master = stimulus side, slave = the timer itself.
interface delay_timer_if;
    logic       start_shifting;
    logic       data;
    logic       ack;
    logic       counting;
    logic       done;
    logic [3:0] count;

    modport master (
        output start_shifting, data, ack,
        input  counting, done, count
    );

    modport slave (
        input  start_shifting, data, ack,
        output counting, done, count
    );
endinterface

// File: rtl/delay_timer.sv
// Loads a 4-bit delay serially after a 0->1 start_shifting edge, counts
// (delay+1)*CYCLES_PER_UNIT cycles, then holds done until ack.
module delay_timer #(
    parameter int unsigned CYCLES_PER_UNIT = 1000
) (
    input  logic          clk,
    input  logic          reset,
    delay_timer_if.slave  bus
);

    localparam int unsigned UW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [UW-1:0] UNIT_MAX = UW'(CYCLES_PER_UNIT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COUNT, DONE} state_t;

    state_t        state;
    logic          start_q;
    logic [3:0]    delay;
    logic [3:0]    delay_next;
    logic [1:0]    idx;
    logic [UW-1:0] unit_cnt;
    logic [3:0]    count_r;
    logic          counting_r;
    logic          done_r;

    // Delay value including the bit being captured this cycle, so the
    // final SHIFT edge can load count with all four bits at once.
    always_comb begin
        delay_next      = delay;
        delay_next[idx] = bus.data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            start_q    <= 1'b1;
            delay      <= '0;
            idx        <= '0;
            unit_cnt   <= '0;
            count_r    <= '0;
            counting_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            start_q <= bus.start_shifting;
            unique case (state)
                IDLE: begin
                    if (bus.start_shifting && !start_q) begin
                        delay <= {bus.data, 3'b000};
                        idx   <= 2'd2;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    delay <= delay_next;
                    if (idx == 2'd0) begin
                        count_r    <= delay_next;
                        unit_cnt   <= '0;
                        counting_r <= 1'b1;
                        state      <= COUNT;
                    end else begin
                        idx <= idx - 2'd1;
                    end
                end
                COUNT: begin
                    if (unit_cnt == UNIT_MAX) begin
                        unit_cnt <= '0;
                        if (count_r != 4'd0) begin
                            count_r <= count_r - 4'd1;
                        end else begin
                            counting_r <= 1'b0;
                            done_r     <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        unit_cnt <= unit_cnt + UW'(1);
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        done_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.counting = counting_r;
    assign bus.done     = done_r;
    assign bus.count    = count_r;

endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer with CYCLES_PER_UNIT=4: stimulus queues
// expected output events, a negedge monitor extracts and compares them.
module tb_delay_timer;

    localparam int CPU = 4;

    // event kinds
    localparam int EV_START = 0;  // counting rose; val = count shown
    localparam int EV_STEP  = 1;  // count changed; val = new + 256*cycles previous value held
    localparam int EV_END   = 2;  // counting fell into done; val = counting length
    localparam int EV_ABORT = 3;  // counting fell without done; val = counting length
    localparam int EV_DONE  = 4;  // done fell; val = done length

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    ev_t  exp_q[$];

    delay_timer_if bus();

    delay_timer #(.CYCLES_PER_UNIT(CPU)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic emit(input int k, input int v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d expected none at %0t", k, v, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL event: got kind=%0d val=%0d expected kind=%0d val=%0d at %0t",
                         k, v, e.kind, e.val, $time);
            end
        end
    endtask

    // Full expected event list for a complete load/count of value d.
    task automatic expect_count(input int d);
        expect_ev(EV_START, d);
        for (int i = d - 1; i >= 0; i--) expect_ev(EV_STEP, i + 256 * CPU);
        expect_ev(EV_END, (d + 1) * CPU);
    endtask

    // Returns #2 after the edge that enters COUNT (trigger edge + 3).
    task automatic load(input logic [3:0] d);
        @(posedge clk); #2 bus.start_shifting = 1'b0;
        @(posedge clk); #2 bus.start_shifting = 1'b1; bus.data = d[3];
        @(posedge clk); #2 bus.data = d[2];
        @(posedge clk); #2 bus.data = d[1];
        @(posedge clk); #2 bus.data = d[0];
        @(posedge clk); #2 bus.data = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_counting"}, int'(bus.counting), 0);
        check({tag, "_done"},     int'(bus.done), 0);
        check({tag, "_count"},    int'(bus.count), 0);
    endtask

    // Monitor
    initial begin : monitor
        int  prev_cnt;
        int  held;
        int  clen;
        int  dlen;
        bit  pc;
        bit  pd;
        prev_cnt = 0; held = 0; clen = 0; dlen = 0; pc = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.counting) begin
                if (!pc) begin
                    emit(EV_START, int'(bus.count));
                    held = 1;
                    clen = 1;
                end else begin
                    clen++;
                    if (int'(bus.count) != prev_cnt) begin
                        emit(EV_STEP, int'(bus.count) + 256 * held);
                        held = 1;
                    end else begin
                        held++;
                    end
                end
                prev_cnt = int'(bus.count);
                if (bus.done) check("counting_and_done", 1, 0);
            end else begin
                if (pc) emit(bus.done ? EV_END : EV_ABORT, clen);
                if (bus.count != 4'd0) check("count_outside_count", int'(bus.count), 0);
            end
            if (bus.done) begin
                dlen = pd ? dlen + 1 : 1;
            end else if (pd) begin
                emit(EV_DONE, dlen);
            end
            pc = bus.counting;
            pd = bus.done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.start_shifting = 1'b0;
        bus.data = 1'b0;
        bus.ack  = 1'b0;

        // reset for one cycle
        @(posedge clk); #2 reset = 1'b1;
        check_idle_outputs("reset");

        // basic load 0101, ack pulse during COUNT, hold ack low 10 cycles in DONE
        expect_count(5);
        expect_ev(EV_DONE, 11);
        load(4'b0101);
        check("basic_count_loaded", int'(bus.count), 5);
        check("basic_counting", int'(bus.counting), 1);
        repeat (5) @(posedge clk);
        #2 bus.ack = 1'b1;
        @(posedge clk); #2 bus.ack = 1'b0;
        repeat (6 * CPU - 6) @(posedge clk);
        #2;
        check("basic_done_rise", int'(bus.done), 1);
        idle_cycles(10);
        check("done_held_no_ack", int'(bus.done), 1);
        bus.ack = 1'b1;
        @(posedge clk); #2 bus.ack = 1'b0;
        check("done_after_ack", int'(bus.done), 0);

        // delay 0, ack held high on entry to DONE, then start held high
        expect_count(0);
        expect_ev(EV_DONE, 1);
        load(4'b0000);
        bus.ack = 1'b1;
        idle_cycles(CPU);
        check("zero_done_rise", int'(bus.done), 1);
        @(posedge clk); #2 bus.ack = 1'b0;
        check("zero_done_one_cycle", int'(bus.done), 0);
        idle_cycles(10);
        check_idle_outputs("no_retrigger");

        // delay 15
        expect_count(15);
        expect_ev(EV_DONE, 1);
        load(4'b1111);
        check("max_count_loaded", int'(bus.count), 15);
        idle_cycles(16 * CPU);
        check("max_done_rise", int'(bus.done), 1);
        bus.ack = 1'b1;
        @(posedge clk); #2 bus.ack = 1'b0;

        // reset mid-COUNT (delay 9) at the 10th COUNT cycle, start stays high
        expect_ev(EV_START, 9);
        expect_ev(EV_STEP, 8 + 256 * CPU);
        expect_ev(EV_STEP, 7 + 256 * CPU);
        expect_ev(EV_ABORT, 10);
        load(4'b1001);
        idle_cycles(9);
        reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        check_idle_outputs("reset_mid_count");
        idle_cycles(8);
        check_idle_outputs("no_trigger_after_reset");

        // reset mid-SHIFT after two bits, then clean 0011 load
        @(posedge clk); #2 bus.start_shifting = 1'b0;
        @(posedge clk); #2 bus.start_shifting = 1'b1; bus.data = 1'b1;
        @(posedge clk); #2 bus.data = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1; bus.data = 1'b0;
        check_idle_outputs("reset_mid_shift");
        idle_cycles(6);
        check_idle_outputs("idle_after_shift_reset");
        expect_count(3);
        expect_ev(EV_DONE, 1);
        load(4'b0011);
        check("post_reset_count_loaded", int'(bus.count), 3);
        idle_cycles(4 * CPU);
        check("post_reset_done_rise", int'(bus.done), 1);
        bus.ack = 1'b1;
        @(posedge clk); #2 bus.ack = 1'b0;

        idle_cycles(4);
        check("events_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_timer.md
# delay_timer

Downstream stage of `sequence_detector_1101`: consumes its `start_shifting` output, shifts in a 4-bit delay value from the same serial `data` line, counts for (delay+1)×`CYCLES_PER_UNIT` clock cycles, then raises `done` until the user acknowledges. Together with the detector it forms the start-pattern → delay-load → timed-wait → acknowledge timer chain of the lab.

## Interface
- `CYCLES_PER_UNIT`, default 1000: clock cycles per delay unit; legal range 1 … 65535.
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-low reset (reset=0 at a rising edge resets).
- `start_shifting`  in  1  from `sequence_detector_1101`; a registered level, may stay high indefinitely.
- `data`  in  1  serial stream shared with the detector; delay bits MSB first.
- `ack`  in  1  user acknowledge; only meaningful in DONE.
- `counting`  out  1  high throughout COUNT.
- `done`  out  1  high throughout DONE.
- `count`  out  4  remaining delay units during COUNT; 0 in every other state.

## Operation
- States: IDLE, SHIFT, COUNT, DONE. All outputs are registered (Moore).
- Edge detect: `start_q` holds the previous `start_shifting`. A trigger is `start_shifting`=1 and `start_q`=0. Only a fresh 0→1 edge starts a load; a held level never retriggers.
- IDLE: on a trigger, capture `data` into `delay[3]`, set bit index to 2, and go to SHIFT. The first cycle in which `start_shifting` reads 1 carries delay bit 3.
- SHIFT: on each edge, capture `data` into `delay[idx]`. After capturing bit 0, load `count` with `delay`, clear the unit counter, and go to COUNT. SHIFT lasts exactly 3 cycles.
- COUNT:
  - The unit counter (width ceil(log2(`CYCLES_PER_UNIT`)), minimum 1) increments each cycle.
  - When it reaches `CYCLES_PER_UNIT`-1 it wraps to 0. If `count`>0, `count` decrements; if `count`=0, go to DONE.
  - COUNT therefore lasts exactly (delay+1)×`CYCLES_PER_UNIT` cycles. delay=0 gives `CYCLES_PER_UNIT` cycles; delay=15 gives 16×`CYCLES_PER_UNIT` cycles.
- DONE: hold `done`=1. When `ack`=1 is sampled, go to IDLE. `done` falls the cycle after `ack` is sampled.
- Ignored inputs:
  - `ack` is ignored outside DONE.
  - `start_shifting` edges are ignored outside IDLE, but `start_q` keeps tracking.
  - `data` is ignored outside IDLE-trigger and SHIFT.
- Reset (reset=0), in any state including mid-SHIFT or mid-COUNT:
  - state=IDLE; `counting`=0, `done`=0, `count`=0; `delay`=0; unit counter=0.
  - `start_q`=1, so a `start_shifting` already high at reset release does not trigger.
- Reset takes priority over every other input at the same edge.

## Timing
- Trigger at edge T: SHIFT during cycles T+1…T+3. `counting` rises after edge T+3; `count`=delay is visible from T+3.
- `count` changes on the edge that wraps the unit counter. `count` shows delay, delay-1, …, 0, each for `CYCLES_PER_UNIT` cycles.
- `counting` falls and `done` rises on the same edge: T+3+(delay+1)×`CYCLES_PER_UNIT`.
- `ack` sampled high at edge A in DONE: `done`=0 after A. A new trigger is accepted from edge A+1 on, provided a 0→1 edge occurs.
- `ack` held high while entering DONE: DONE lasts exactly 1 cycle.

## Test plan
Benches use `CYCLES_PER_UNIT`=4.
- Basic load and count: reset=0 for 1 cycle, then `start_shifting` 0→1 with `data` bits 0,1,0,1 on consecutive cycles → `count`=5 after the 4th bit; `counting`=1 for 24 cycles; `count` steps 5,4,3,2,1,0 every 4 cycles; then `done`=1.
- Boundary delays:
  - delay=0000 → `counting` for exactly 4 cycles, `count`=0 throughout.
  - delay=1111 → `counting` for exactly 64 cycles, `count` starts at 15.
- Handshake:
  - Hold `ack`=0 for 10 cycles in DONE → `done` stays 1.
  - Pulse `ack` during COUNT → ignored; COUNT length unchanged.
  - `ack`=1 in DONE → `done`=0 next cycle, state IDLE.
- No retrigger: keep `start_shifting` high through the whole sequence and after `ack` → block stays IDLE. Drop it to 0 and raise it again → a new load starts.
- Reset mid-COUNT (delay=9, reset=0 at cycle 10 of COUNT) → next cycle `counting`=0, `count`=0, `done`=0. `start_shifting` still high at reset release → no trigger.
- Reset mid-SHIFT after 2 bits → IDLE, all outputs 0. A subsequent clean trigger with bits 0011 → `count`=3 and COUNT lasts 16 cycles.
